// File: rtl/gyro_stream_pkg.sv
// Shared definitions for the gyro stream depacketizer.
//   WORDS_DEF / DATA_W_DEF : default packet geometry
//   COLLECT / DISCARD      : framing FSM state encoding
//   clog2()                : index width helper
package gyro_stream_pkg;

  localparam int unsigned WORDS_DEF  = 8;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  // Smallest w with 2**w >= value (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 1; i < value; i = i << 1) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/gyro_frame_buffer.sv
// Holding buffer for one committed packet.
//   clock_i, reset_i : clock, synchronous active-high reset
//   load_i           : bulk-load all WORDS words from load_data_i
//   load_data_i      : full packet, word k in slot k
//   rd_addr_i        : word index to read
//   rd_data_o        : registered read data (one cycle after rd_addr_i)
module gyro_frame_buffer import gyro_stream_pkg::*; #(
  parameter int unsigned WORDS  = WORDS_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned IDX_W = clog2(WORDS)
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             load_i,
  input  logic [WORDS-1:0][DATA_W-1:0]     load_data_i,
  input  logic [IDX_W-1:0]                 rd_addr_i,
  output logic [DATA_W-1:0]                rd_data_o
);

  logic [WORDS-1:0][DATA_W-1:0] hold_q;
  logic [DATA_W-1:0]            rd_data_q;

  // Contents are don't-care after reset, so the array itself is not reset.
  always_ff @(posedge clock_i) begin
    if (load_i) begin
      hold_q <= load_data_i;
    end
  end

  // Reads sample hold_q before a same-cycle load lands, so the old packet is seen.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= hold_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gyro_stream_depacketizer.sv
// Depacketizer for the gyro packetizer stream (fixed WORDS-word packets).
//   clock_i, reset_i          : clock, synchronous active-high reset
//   s_tdata_i/tvalid_i/tlast_i: input stream, no back-pressure
//   rd_addr_i, rd_data_o      : host read of the held packet (registered)
//   pkt_ack_i                 : host consumed the held packet
//   err_clear_i               : clear sticky error flags
//   pkt_pending_o, pkt_irq_o  : held packet present / one-cycle commit pulse
//   err_short/long/overrun_o  : sticky framing errors
//   pkt_count_o, drop_count_o : committed (wrapping) / dropped (saturating) counts
module gyro_stream_depacketizer import gyro_stream_pkg::*; #(
  parameter int unsigned WORDS  = WORDS_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned IDX_W = clog2(WORDS)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] s_tdata_i,
  input  logic              s_tvalid_i,
  input  logic              s_tlast_i,
  input  logic [IDX_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              pkt_ack_i,
  input  logic              err_clear_i,
  output logic              pkt_pending_o,
  output logic              pkt_irq_o,
  output logic              err_short_o,
  output logic              err_long_o,
  output logic              err_overrun_o,
  output logic [CNT_W-1:0]  pkt_count_o,
  output logic [CNT_W-1:0]  drop_count_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORDS - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             irq_q;
  logic             short_q, short_d, long_q, long_d, overrun_q, overrun_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d, drop_count_q, drop_count_d;

  // Only words 0..WORDS-2 are stored; the last word is taken straight from the
  // stream on the commit cycle, so it never needs a register slot.
  logic [WORDS-2:0][DATA_W-1:0] collect_q, collect_d;
  logic [WORDS-1:0][DATA_W-1:0] commit_data;

  logic commit, drop, set_short, set_long, set_overrun;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    collect_d   = collect_q;
    commit      = 1'b0;
    drop        = 1'b0;
    set_short   = 1'b0;
    set_long    = 1'b0;
    set_overrun = 1'b0;
    commit_data = {s_tdata_i, collect_q};

    if (s_tvalid_i) begin
      if (state_q == COLLECT) begin
        if (s_tlast_i && idx_q == LastIdx) begin
          idx_d = '0;
          if (!pending_q || pkt_ack_i) begin
            commit = 1'b1;
          end else begin
            set_overrun = 1'b1;
            drop        = 1'b1;
          end
        end else if (s_tlast_i) begin
          set_short = 1'b1;
          drop      = 1'b1;
          idx_d     = '0;
        end else if (idx_q == LastIdx) begin
          set_long = 1'b1;
          drop     = 1'b1;
          idx_d    = '0;
          state_d  = DISCARD;
        end else begin
          collect_d[idx_q] = s_tdata_i;
          idx_d            = idx_q + IDX_W'(1);
        end
      end else if (s_tlast_i) begin
        state_d = COLLECT;
        idx_d   = '0;
      end
    end

    // A commit in the same cycle as an ack keeps the new packet pending.
    if (commit) begin
      pending_d = 1'b1;
    end else if (pkt_ack_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    // Set has priority over clear.
    short_d   = set_short   | (short_q   & ~err_clear_i);
    long_d    = set_long    | (long_q    & ~err_clear_i);
    overrun_d = set_overrun | (overrun_q & ~err_clear_i);

    pkt_count_d  = pkt_count_q + CNT_W'(commit);
    drop_count_d = drop_count_q;
    if (drop && drop_count_q != {CNT_W{1'b1}}) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= COLLECT;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      irq_q        <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      overrun_q    <= 1'b0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      irq_q        <= commit;
      short_q      <= short_d;
      long_q       <= long_d;
      overrun_q    <= overrun_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Partial-packet contents are meaningless after reset; no reset needed.
  always_ff @(posedge clock_i) begin
    collect_q <= collect_d;
  end

  gyro_frame_buffer #(
    .WORDS  (WORDS),
    .DATA_W (DATA_W)
  ) u_frame_buffer (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .load_i      (commit),
    .load_data_i (commit_data),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o)
  );

  assign pkt_pending_o = pending_q;
  assign pkt_irq_o     = irq_q;
  assign err_short_o   = short_q;
  assign err_long_o    = long_q;
  assign err_overrun_o = overrun_q;
  assign pkt_count_o   = pkt_count_q;
  assign drop_count_o  = drop_count_q;

endmodule

// File: doc/gyro_stream_depacketizer.md
Name: gyro_stream_depacketizer

Overview:
- Downstream consumer of the gyro packetizer's stream (TDATA/TVALID/TLAST, fixed 8-word packets).
- Validates packet framing and assembles each packet into a collect buffer.
- Commits each good packet to a holding buffer and signals the host side.
- Flags short, long and overrun packets with sticky errors; host reads committed words by index.

Parameters:
- WORDS, 8, words per packet; power of two, >= 2.
- DATA_W, 32, stream word width.
- CNT_W, 16, width of the good-packet and dropped-packet counters.

Ports:
- clock, input, 1: single clock for all logic.
- reset, input, 1: synchronous, active-high.
- s_tdata, input, DATA_W: stream data.
- s_tvalid, input, 1: word valid. No back-pressure; the block always accepts.
- s_tlast, input, 1: final word of a packet; qualified by s_tvalid.
- rd_addr, input, log2(WORDS): word index into the holding buffer.
- rd_data, output, DATA_W: holding-buffer word at rd_addr, registered.
- pkt_ack, input, 1: host has consumed the held packet; clears pkt_pending.
- err_clear, input, 1: clears all sticky error flags.
- pkt_pending, output, 1: holding buffer contains an unacknowledged packet.
- pkt_irq, output, 1: one-cycle pulse on each commit.
- err_short, output, 1: sticky; a packet ended with fewer than WORDS words.
- err_long, output, 1: sticky; a packet exceeded WORDS words.
- err_overrun, output, 1: sticky; a good packet arrived while pkt_pending=1.
- pkt_count, output, CNT_W: number of committed packets; wraps.
- drop_count, output, CNT_W: number of dropped packets of any cause; saturates at all-ones.

Behaviour:
- Reset: all outputs 0, word index 0, FSM in COLLECT. Buffer contents are don't-care but rd_data reads 0. Reset mid-packet discards the partial packet and counts nothing.
- An accepted word is a cycle with s_tvalid=1. s_tdata and s_tlast are ignored when s_tvalid=0; gaps of any length are legal.
- FSM state COLLECT, on each accepted word: write s_tdata to collect[idx].
  - s_tlast=1 and idx==WORDS-1: good packet.
    - If pkt_pending=0 or pkt_ack=1 this cycle: commit. Copy the full collect buffer, including this word, into the holding buffer at the next edge; set pkt_pending; pulse pkt_irq; increment pkt_count.
    - Otherwise: drop the packet, set err_overrun, increment drop_count. The holding buffer is untouched.
    - In both cases idx returns to 0.
  - s_tlast=1 and idx<WORDS-1: set err_short, increment drop_count, idx returns to 0. Remain in COLLECT.
  - s_tlast=0 and idx==WORDS-1: set err_long, increment drop_count, go to DISCARD.
  - Otherwise: idx increments.
- FSM state DISCARD: accepted words are ignored. An accepted word with s_tlast=1 returns the FSM to COLLECT with idx=0. The packet is counted once, on entry to DISCARD.
- pkt_ack:
  - Clears pkt_pending at the next edge unless a commit occurs in the same cycle; commit wins, so pkt_pending stays 1.
  - pkt_ack with pkt_pending=0 is a no-op.
- err_clear clears the three sticky flags at the next edge. If an error event occurs in the same cycle, the set wins.
- Commit latency: holding buffer, pkt_pending and pkt_irq all update one cycle after the last word.
- rd_data: rd_data = hold[rd_addr] registered, so it is valid 1 cycle after rd_addr. During the commit cycle the old contents are read; from the next cycle, the new contents.
- pkt_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package gyro_stream_pkg:
  - WORDS and DATA_W defaults.
  - FSM state encoding: COLLECT=1'b0, DISCARD=1'b1.
  - Index width function clog2.
- One sub-module, gyro_frame_buffer: WORDS×DATA_W holding register array with a bulk-load port and a registered read port. Collect buffer, FSM and counters stay in the top level.

Test Plan:
- Good packet: 8 back-to-back words 0x1000..0x1007, tlast on the 8th -> pkt_irq one cycle after the last word; pkt_pending=1; pkt_count=1; rd_addr=3 gives 0x1003 next cycle.
- Gaps: the same packet with s_tvalid low for 2 cycles between each word -> identical result to back-to-back.
- Short: tlast on the 5th word, then a good packet -> err_short=1; drop_count=1; the following packet commits correctly with pkt_count=1.
- Long: 11 words, tlast on the 11th, then a good packet -> err_long=1; drop_count=1; words 9–11 ignored; the next packet commits and the holding buffer holds only the new data.
- Overrun: two good packets with no pkt_ack -> err_overrun=1; drop_count=1; holding buffer still shows packet 1. Repeat with pkt_ack asserted on the 2nd packet's last-word cycle -> commit; pkt_pending stays 1; pkt_count increments.
- Clear/reset: err_clear in the same cycle as a short packet -> err_short stays 1. Reset after 4 words of a packet -> all outputs 0; the next full packet commits with pkt_count=1.
